sram_arbiter: RTL and testbench

Two-port arbiter and cycle sequencer for the board's single asynchronous 16-bit SRAM. It shares the SRAM between the CPU memory path (MAR/MDR fetch, load and store traffic from the control unit) and a second requester, the program-loader/debug port. It also generates all chip strobes with fixed setup and access timing. The control unit and the loader present simple request/done handshakes instead of driving Mem_* directly.

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_pick.sv | 34 +++
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_ADDR_W        = 20;
    localparam int DEF_DATA_W        = 16;
    localparam int DEF_ACCESS_CYCLES = 2;
    // Wide enough for ACCESS_CYCLES up to 15.
    localparam int TIMER_W           = 4;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_t;
    typedef enum logic {CPU = 1'b0, DEV = 1'b1} req_id_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner select between the CPU path and the loader port.
// SRAM_ARB_RR_EN: round-robin on a tie; otherwise the CPU always wins a tie.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dev_req,
    input  req_id_t last_grant,
    output logic    any_req,
    output req_id_t winner
);

    logic tie_cpu;

`ifdef SRAM_ARB_RR_EN
    // The requester that did not win last time takes the tie.
    assign tie_cpu = (last_grant == DEV);
`else
    // Fixed priority ignores grant history; the register behind it has no load.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_cpu = 1'b1;
`endif

    assign any_req = cpu_req | dev_req;

    // A lone requester wins; a tie goes to the CPU only when tie_cpu allows it.
    always_comb begin
        winner = DEV;
        if (cpu_req && (!dev_req || tie_cpu))
            winner = CPU;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the asynchronous 16-bit SRAM.
// Sequence per access: IDLE -> SETUP (1) -> ACCESS (ACCESS_CYCLES) -> DONE (1).
// All Mem_* outputs come straight from registers, never from the req inputs.
// Optional macro SRAM_ARB_RR_EN selects round-robin tie breaking (see sram_arb_pick).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              dev_done,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              busy,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Dout_en,
    input  logic [DATA_W-1:0] Mem_Din
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } op_t;

    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(ACCESS_CYCLES - 1);

    arb_state_t         state;
    // Owner of the current/most recent grant; doubles as last-grant for round-robin.
    req_id_t            owner;
    req_id_t            winner;
    logic               any_req;
    op_t                op;
    op_t                grant_op;
    logic [TIMER_W-1:0] timer;

    sram_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dev_req    (dev_req),
        .last_grant (owner),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign grant_op = (winner == CPU) ? {cpu_we, cpu_addr, cpu_wdata}
                                      : {dev_we, dev_addr, dev_wdata};

    // Address and write data only change at grant, so they are stable
    // for a full cycle on both sides of the WE pulse.
    assign Mem_ADDR = op.addr;
    assign Mem_Dout = op.wdata;
    assign busy     = (state != IDLE);

    // Access sequencer: grant, strobe timing, read capture and done pulses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            owner       <= DEV;
            op          <= '0;
            timer       <= '0;
            Mem_CE      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            Mem_UB      <= 1'b1;
            Mem_LB      <= 1'b1;
            Mem_Dout_en <= 1'b0;
            cpu_done    <= 1'b0;
            dev_done    <= 1'b0;
            cpu_rdata   <= '0;
            dev_rdata   <= '0;
        end else begin
            cpu_done <= 1'b0;
            dev_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= winner;
                        op          <= grant_op;
                        Mem_CE      <= 1'b0;
                        Mem_UB      <= 1'b0;
                        Mem_LB      <= 1'b0;
                        Mem_Dout_en <= grant_op.we;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    timer  <= '0;
                    Mem_OE <= op.we;
                    Mem_WE <= !op.we;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    timer <= timer + TIMER_W'(1);
                    if (timer == LAST_TICK) begin
                        if (!op.we) begin
                            if (owner == CPU) cpu_rdata <= Mem_Din;
                            else              dev_rdata <= Mem_Din;
                        end
                        cpu_done    <= (owner == CPU);
                        dev_done    <= (owner == DEV);
                        Mem_CE      <= 1'b1;
                        Mem_OE      <= 1'b1;
                        Mem_WE      <= 1'b1;
                        Mem_UB      <= 1'b1;
                        Mem_LB      <= 1'b1;
                        Mem_Dout_en <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: three lanes with ACCESS_CYCLES = 2, 1, 15.
// Each lane has two random requesters, a transaction-level reference model that
// grants by the arbitration rules and pushes the expected access into a queue,
// an SRAM model on the bus, and a monitor that pops and checks every cycle.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int ln,
                                input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, ln, $time, got, want);
        end
    endfunction

    typedef struct {
        int          who;    // 0 = CPU, 1 = DEV
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          g;      // cycle index of the granting edge
    } txn_t;

    for (genvar L = 0; L < 3; L++) begin : lane
        localparam int AC = (L == 0) ? 2 : (L == 1) ? 1 : 15;

        logic             rst_n = 1'b0;
        logic [1:0]       req   = '0;
        logic [1:0]       we    = '0;
        logic [1:0][19:0] addr  = '0;
        logic [1:0][15:0] wdata = '0;

        logic        cpu_done, dev_done, busy;
        logic [15:0] cpu_rdata, dev_rdata;
        logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, Mem_Dout_en;
        logic [19:0] Mem_ADDR;
        logic [15:0] Mem_Dout, Mem_Din;

        sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
            .Clk(Clk), .Reset(rst_n),
            .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
            .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
            .dev_req(req[1]), .dev_we(we[1]), .dev_addr(addr[1]), .dev_wdata(wdata[1]),
            .dev_done(dev_done), .dev_rdata(dev_rdata),
            .busy(busy),
            .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
            .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Dout_en(Mem_Dout_en), .Mem_Din(Mem_Din)
        );

        txn_t        q[$];
        logic [15:0] sram    [256];
        logic [15:0] ref_mem [256];
        logic [15:0] mrd     [2];
        int          cyc = 0;
        int          next_free = 0;
        int          n_cpu = 0;
        bit          stop = 0;
        bit          fin = 0;
`ifdef SRAM_ARB_RR_EN
        int          last = 1;
`endif

        initial begin
            for (int i = 0; i < 256; i++) begin
                sram[i]    = 16'(i * 257) ^ 16'h5A5A;
                ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
            end
            mrd[0] = '0;
            mrd[1] = '0;
        end

        // Bus-side SRAM: reads while CE and OE are low, writes on every WE-low edge.
        assign Mem_Din = (!Mem_CE && !Mem_OE) ? sram[Mem_ADDR[7:0]] : 16'hDEAD;
        always @(posedge Clk)
            if (!Mem_CE && !Mem_WE) sram[Mem_ADDR[7:0]] <= Mem_Dout;

        // Reference model: grants by rule, one access per (AC+3) cycles at most.
        always @(posedge Clk) begin
            txn_t t;
            cyc++;
            if (!rst_n) begin
                q.delete();
                next_free = cyc + 1;
                mrd[0] = '0;
                mrd[1] = '0;
`ifdef SRAM_ARB_RR_EN
                last = 1;
`endif
            end else if (cyc >= next_free && req != 2'b00) begin
                if (req == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
                    t.who = (last == 0) ? 1 : 0;
`else
                    t.who = 0;
`endif
                end else begin
                    t.who = req[0] ? 0 : 1;
                end
                t.we    = we[t.who];
                t.addr  = addr[t.who];
                t.wdata = wdata[t.who];
                t.rdata = ref_mem[t.addr[7:0]];
                if (t.we) ref_mem[t.addr[7:0]] = t.wdata;
                t.g = cyc;
                q.push_back(t);
`ifdef SRAM_ARB_RR_EN
                last = t.who;
`endif
                next_free = cyc + AC + 3;
            end
        end

        task automatic new_op(input int p);
            req[p] = 1'b1;
            if (p == 0 && n_cpu < 2) begin
                // First CPU write BEEF to 00123, then read it back.
                we[p]    = (n_cpu == 0);
                addr[p]  = 20'h00123;
                wdata[p] = 16'hBEEF;
            end else begin
                we[p]    = 1'($urandom);
                addr[p]  = {12'($urandom), 8'h20 + 8'($urandom_range(15))};
                wdata[p] = 16'($urandom);
            end
            if (p == 0) n_cpu++;
        endtask

        // Requesters: hold req until done, sometimes re-request back to back,
        // scramble operands or drop req while their access is in flight.
        always begin
            @(posedge Clk);
            #2;
            for (int p = 0; p < 2; p++) begin
                bit infl, dn;
                infl = (q.size() > 0) && (q[0].who == p);
                dn   = infl && (q[0].g + AC + 1 == cyc);
                if (stop) begin
                    if (!infl || dn) req[p] = 1'b0;
                end else if (dn) begin
                    if ($urandom_range(1) == 0) req[p] = 1'b0;
                    else                        new_op(p);
                end else if (infl) begin
                    if ($urandom_range(3) == 0) begin
                        we[p]    = 1'($urandom);
                        addr[p]  = 20'($urandom);
                        wdata[p] = 16'($urandom);
                    end
                    if ($urandom_range(15) == 0) req[p] = 1'b0;
                end else if (!req[p] && $urandom_range(2) == 0) begin
                    new_op(p);
                end
            end
        end

        // Monitor: pop the expected access and compare the whole bus every cycle.
        always @(negedge Clk) begin
            txn_t f;
            bit   due, act, ce_lo, acc;
            int   ph;
            due = 0; act = 0; ph = 0;
            if (q.size() > 0) begin
                f   = q[0];
                ph  = cyc - f.g;
                act = (ph >= 0) && (ph <= AC + 1);
                due = (ph == AC + 1);
            end
            if (due && !f.we) mrd[f.who] = f.rdata;
            ce_lo = act && (ph <= AC);
            acc   = act && (ph >= 1) && (ph <= AC);
            chk("cpu_done", L, 32'(cpu_done), 32'(due && f.who == 0));
            chk("dev_done", L, 32'(dev_done), 32'(due && f.who == 1));
            chk("cpu_rdata", L, 32'(cpu_rdata), 32'(mrd[0]));
            chk("dev_rdata", L, 32'(dev_rdata), 32'(mrd[1]));
            chk("busy", L, 32'(busy), 32'(act));
            chk("strobes{CE,UB,LB,OE,WE,EN}", L,
                32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Dout_en}),
                32'({!ce_lo, !ce_lo, !ce_lo, !(acc && !f.we), !(acc && f.we), ce_lo && f.we}));
            if (act) chk("Mem_ADDR", L, 32'(Mem_ADDR), 32'(f.addr));
            if (ce_lo && f.we) chk("Mem_Dout", L, 32'(Mem_Dout), 32'(f.wdata));
            if (due) void'(q.pop_front());
        end

        // Lane sequence: reset, random traffic, reset inside a write, more traffic, drain.
        initial begin
            int w;
            repeat (3) @(posedge Clk);
            #2 rst_n = 1'b1;
            repeat (300) @(posedge Clk);
            #2;
            w = 0;
            while (!(q.size() > 0 && q[0].we && cyc == q[0].g + 1) && w < 3000) begin
                @(posedge Clk);
                #2;
                w++;
            end
            chk("rst_window_found", L, 32'(w < 3000), 32'd1);
            rst_n = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            chk("rst_state{WE,CE,EN,busy,cd,dd}", L,
                32'({Mem_WE, Mem_CE, Mem_Dout_en, busy, cpu_done, dev_done}), 32'(6'b110000));
            @(posedge Clk);
            #2 rst_n = 1'b1;
            repeat (1500) @(posedge Clk);
            #2 stop = 1'b1;
            w = 0;
            while (q.size() > 0 && w < 60) begin
                @(posedge Clk);
                w++;
            end
            chk("drain", L, 32'(q.size()), 32'd0);
            repeat (3) @(posedge Clk);
            fin = 1'b1;
        end
    end

    initial begin
        wait (lane[0].fin && lane[1].fin && lane[2].fin);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: lanes did not finish");
        $fatal(1);
    end

endmodule
